// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_BITS = 6;

    // Controller states; the numeric value is exported on state_dbg
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_SLTI_EX  = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JUMP     = 4'd12,
        S_ERROR    = 4'd13
    } state_e;

    // Supported opcodes (instruction bits [31:26])
    localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_BITS-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_BITS-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_BITS-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_BITS-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_BITS-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_BITS-1:0] OP_J     = 6'b000010;

    // ALUCtrl codes for the downstream ALU control decoder
    localparam logic [1:0] ALUCTRL_ADD   = 2'b00;
    localparam logic [1:0] ALUCTRL_SUB   = 2'b01;
    localparam logic [1:0] ALUCTRL_RTYPE = 2'b10;
    localparam logic [1:0] ALUCTRL_SLT   = 2'b11;

    // ALU B operand selects
    localparam logic [1:0] ALUSRCB_REGB    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control word held in the output register
    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
    } ctrl_t;

    // Control word for a state; anything not set for the state stays 0
    function automatic ctrl_t ctrl_for_state(input state_e s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_a = 1'b0;
                c.alu_src_b = ALUSRCB_FOUR;
                c.alu_ctrl  = ALUCTRL_ADD;
                c.pc_src    = PCSRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 1'b0;
                c.alu_src_b = ALUSRCB_IMM_SH2;
                c.alu_ctrl  = ALUCTRL_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_ctrl  = ALUCTRL_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b0;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_REGB;
                c.alu_ctrl  = ALUCTRL_RTYPE;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_REGB;
                c.alu_ctrl  = ALUCTRL_SUB;
                c.branch    = 1'b1;
                c.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_ctrl  = ALUCTRL_ADD;
            end
            S_SLTI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_ctrl  = ALUCTRL_SLT;
            end
            S_IMM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b0;
                c.mem_to_reg = 1'b0;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, driving datapath enables/selects.
module mips_multicycle_control #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned OPCODE_W      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [1:0]          ALUCtrl,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                PCWrite,
    output logic                Branch,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic [1:0]          PCSrc,
    output logic                illegal_op,
    output logic [3:0]          state_dbg
);

    import mips_ctrl_pkg::*;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   mem_done;

    // A memory transfer completes this cycle (always, for single-cycle memory)
    assign mem_done = !MEM_HANDSHAKE || mem_ready;

    // Next-state selection; opcode only matters in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OPCODE_W'(OP_RTYPE))      state_d = S_RTYPE_EX;
                else if (opcode == OPCODE_W'(OP_LW))    state_d = S_MEMADR;
                else if (opcode == OPCODE_W'(OP_SW))    state_d = S_MEMADR;
                else if (opcode == OPCODE_W'(OP_BEQ))   state_d = S_BEQ;
                else if (opcode == OPCODE_W'(OP_ADDI))  state_d = S_ADDI_EX;
                else if (opcode == OPCODE_W'(OP_SLTI))  state_d = S_SLTI_EX;
                else if (opcode == OPCODE_W'(OP_J))     state_d = S_JUMP;
                else                                    state_d = S_ERROR;
            end
            S_MEMADR: begin
                // Anything that is not a store is treated as a read: never write by accident
                state_d = (opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_done) state_d = S_FETCH;
            end
            S_RTYPE_EX: state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_IMM_WB;
            S_SLTI_EX:  state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // State and control word registers; control is decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_for_state(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for_state(state_d);
            if (state_d == S_ERROR) illegal_q <= 1'b1;
        end
    end

    // Fetch commits IR and PC only on the cycle the memory delivers the word
    assign IRWrite    = ctrl_q.ir_write & mem_done;
    assign PCWrite    = ctrl_q.pc_write & ((state_q != S_FETCH) | mem_done);

    assign ALUCtrl    = ctrl_q.alu_ctrl;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign IorD       = ctrl_q.iord;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign Branch     = ctrl_q.branch;
    assign RegDst     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign PCSrc      = ctrl_q.pc_src;
    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control (memory handshake enabled).
module tb_mips_multicycle_control;

    import mips_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALUCtrl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       Branch;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(
        .MEM_HANDSHAKE(1'b1),
        .OPCODE_W     (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ALUCtrl   (ALUCtrl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .PCSrc     (PCSrc),
        .illegal_op(illegal_op),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector {ALUCtrl,ALUSrcA,ALUSrcB,IorD,IRWrite,MemRead,MemWrite,
    // RegWrite,PCWrite,Branch,RegDst,MemtoReg,PCSrc,illegal_op} from the state table
    function automatic logic [16:0] exp_out(input state_e s, input logic rdy);
        logic [1:0] alu, srcb, pcs;
        logic srca, iord, irw, mr, mw, rw, pcw, br, rd, m2r, ill;
        {alu, srcb, pcs} = '0;
        {srca, iord, irw, mr, mw, rw, pcw, br, rd, m2r, ill} = '0;
        case (s)
            S_FETCH:    begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
            S_DECODE:   begin srcb = 2'b11; end
            S_MEMADR:   begin srca = 1; srcb = 2'b10; end
            S_MEMRD:    begin mr = 1; iord = 1; end
            S_MEMWB:    begin rw = 1; m2r = 1; end
            S_MEMWR:    begin mw = 1; iord = 1; end
            S_RTYPE_EX: begin srca = 1; alu = 2'b10; end
            S_ALU_WB:   begin rw = 1; rd = 1; end
            S_BEQ:      begin srca = 1; alu = 2'b01; br = 1; pcs = 2'b01; end
            S_ADDI_EX:  begin srca = 1; srcb = 2'b10; end
            S_SLTI_EX:  begin srca = 1; srcb = 2'b10; alu = 2'b11; end
            S_IMM_WB:   begin rw = 1; end
            S_JUMP:     begin pcw = 1; pcs = 2'b10; end
            S_ERROR:    begin ill = 1; end
            default:    begin end
        endcase
        return {alu, srca, srcb, iord, irw, mr, mw, rw, pcw, br, rd, m2r, pcs, ill};
    endfunction

    // One clock cycle: drive inputs at negedge, then check current state/outputs
    task automatic cycle(input state_e exp_st, input logic rdy, input logic [5:0] op,
                         input logic rst_v, input bit chk_out, input string tag);
        logic [16:0] obs;
        logic [16:0] exp_v;
        @(negedge clk);
        rst       = rst_v;
        mem_ready = rdy;
        opcode    = op;
        #1;
        checks++;
        assert (state_dbg === 4'(exp_st)) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, exp_st);
        end
        if (chk_out) begin
            obs = {ALUCtrl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemRead, MemWrite, RegWrite,
                   PCWrite, Branch, RegDst, MemtoReg, PCSrc, illegal_op};
            exp_v = exp_out(exp_st, rdy);
            checks++;
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s outputs in state %0d: observed %05h expected %05h",
                       tag, exp_st, obs, exp_v);
            end
        end
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Run one instruction from FETCH: waits are memory stall cycles
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input string tag);
        state_e q_st[$];
        logic   q_rdy[$];
        state_e mem_st;
        for (int i = 0; i < wf; i++) begin q_st.push_back(S_FETCH); q_rdy.push_back(1'b0); end
        q_st.push_back(S_FETCH);  q_rdy.push_back(1'b1);
        q_st.push_back(S_DECODE); q_rdy.push_back(rnd_bit());
        case (op)
            6'b100011, 6'b101011: begin
                q_st.push_back(S_MEMADR); q_rdy.push_back(rnd_bit());
                mem_st = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
                for (int i = 0; i < wm; i++) begin q_st.push_back(mem_st); q_rdy.push_back(1'b0); end
                q_st.push_back(mem_st); q_rdy.push_back(1'b1);
                if (op == 6'b100011) begin q_st.push_back(S_MEMWB); q_rdy.push_back(rnd_bit()); end
            end
            6'b000000: begin
                q_st.push_back(S_RTYPE_EX); q_rdy.push_back(rnd_bit());
                q_st.push_back(S_ALU_WB);   q_rdy.push_back(rnd_bit());
            end
            6'b000100: begin q_st.push_back(S_BEQ); q_rdy.push_back(rnd_bit()); end
            6'b001000: begin
                q_st.push_back(S_ADDI_EX); q_rdy.push_back(rnd_bit());
                q_st.push_back(S_IMM_WB);  q_rdy.push_back(rnd_bit());
            end
            6'b001010: begin
                q_st.push_back(S_SLTI_EX); q_rdy.push_back(rnd_bit());
                q_st.push_back(S_IMM_WB);  q_rdy.push_back(rnd_bit());
            end
            6'b000010: begin q_st.push_back(S_JUMP); q_rdy.push_back(rnd_bit()); end
            default: begin end
        endcase
        foreach (q_st[i]) begin
            // Opcode is meaningful only while decoding/addressing; scramble it elsewhere
            cycle(q_st[i], q_rdy[i],
                  (q_st[i] == S_DECODE || q_st[i] == S_MEMADR) ? op : rnd_op(),
                  1'b0, 1'b1, tag);
        end
    endtask

    logic [5:0] legal [7];
    logic [5:0] bad_op;
    bit         is_legal;

    initial begin
        legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
        legal[3] = 6'b000100; legal[4] = 6'b001000; legal[5] = 6'b001010;
        legal[6] = 6'b000010;

        rst = 1'b1; mem_ready = 1'b0; opcode = 6'b0;
        @(negedge clk);
        @(negedge clk);
        cycle(S_FETCH, 1'b0, rnd_op(), 1'b0, 1'b1, "reset");

        // Directed instructions
        run_instr(6'b100011, 1, 2, "lw");
        run_instr(6'b000000, 0, 0, "rtype");
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b001010, 0, 0, "slti");
        run_instr(6'b000010, 0, 0, "j");
        run_instr(6'b101011, 0, 3, "sw");
        run_instr(6'b001000, 2, 0, "addi");

        // Reset mid-store, with mem_ready high on the first reset cycle
        cycle(S_FETCH,  1'b1,      rnd_op(),  1'b0, 1'b1, "rst_mid");
        cycle(S_DECODE, rnd_bit(), 6'b101011, 1'b0, 1'b1, "rst_mid");
        cycle(S_MEMADR, rnd_bit(), 6'b101011, 1'b0, 1'b1, "rst_mid");
        cycle(S_MEMWR,  1'b0,      rnd_op(),  1'b0, 1'b1, "rst_mid");
        cycle(S_MEMWR,  1'b1,      rnd_op(),  1'b1, 1'b1, "rst_mid");
        cycle(S_FETCH,  1'b1,      rnd_op(),  1'b1, 1'b0, "rst_mid");
        cycle(S_FETCH,  1'b0,      rnd_op(),  1'b0, 1'b1, "after_rst");

        // Randomized legal instruction stream with random stalls
        for (int n = 0; n < 40; n++) begin
            run_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 3),
                      $urandom_range(0, 3), "random");
        end

        // Illegal opcode: ERROR is sticky until reset
        cycle(S_FETCH,  1'b1, rnd_op(),  1'b0, 1'b1, "illegal");
        cycle(S_DECODE, 1'b0, 6'b111111, 1'b0, 1'b1, "illegal");
        for (int n = 0; n < 20; n++) begin
            cycle(S_ERROR, rnd_bit(), rnd_op(), 1'b0, 1'b1, "error_hold");
        end
        cycle(S_ERROR, rnd_bit(), rnd_op(), 1'b1, 1'b1, "error_rst");
        cycle(S_FETCH, 1'b0, rnd_op(), 1'b0, 1'b1, "error_cleared");

        // A random unsupported opcode
        do begin
            bad_op   = rnd_op();
            is_legal = 1'b0;
            foreach (legal[k]) if (legal[k] == bad_op) is_legal = 1'b1;
        end while (is_legal);
        cycle(S_FETCH,  1'b1,   rnd_op(), 1'b0, 1'b1, "illegal_rnd");
        cycle(S_DECODE, 1'b1,   bad_op,   1'b0, 1'b1, "illegal_rnd");
        cycle(S_ERROR,  1'b1,   rnd_op(), 1'b0, 1'b1, "illegal_rnd");
        cycle(S_ERROR,  1'b0,   rnd_op(), 1'b1, 1'b1, "illegal_rnd");
        cycle(S_FETCH,  1'b0,   rnd_op(), 1'b0, 1'b1, "illegal_rnd_cleared");
        run_instr(6'b000010, 0, 0, "j_after");
        cycle(S_FETCH, 1'b0, rnd_op(), 1'b0, 1'b1, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Produces the 2-bit ALUCtrl code consumed by the ALU control decoder, plus all datapath enables and mux selects.
- Sits between the instruction register's opcode field and the datapath; holds in memory states until memory acknowledges.

Parameters:
- MEM_HANDSHAKE, 1, when 1 the FETCH/MEMRD/MEMWR states hold until mem_ready=1; when 0 mem_ready is ignored (single-cycle memory).
- OPCODE_W, 6, opcode field width (instruction bits [31:26]).

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- opcode  input  OPCODE_W  instruction [31:26] from the instruction register, sampled in DECODE
- mem_ready  input  1  memory transfer complete this cycle
- ALUCtrl  output  2  00 ADD, 01 SUB, 10 R-type (funct-decoded downstream), 11 SLT/greater
- ALUSrcA  output  1  0 PC, 1 register A
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- IorD  output  1  memory address: 0 PC, 1 ALUOut
- IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch  output  1 each  enables
- RegDst, MemtoReg  output  1 each  writeback selects
- PCSrc  output  2  00 ALU, 01 ALUOut, 10 jump target
- illegal_op  output  1  sticky: unsupported opcode decoded
- state_dbg  output  4  current state encoding

Behaviour:
- Moore FSM; all outputs decoded from the state register only, with no opcode-to-output combinational path.
- Every output not listed for a state is 0.
- Reset: rst=1 at a clock edge puts the FSM in FETCH and clears illegal_op.
  - The remaining outputs take FETCH values, so ALUCtrl=00 after reset.
  - Reset mid-instruction aborts it with no partial write. RegWrite/MemWrite are 0 in the cycle after reset.
- States and outputs:
  - FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUCtrl=00, PCSrc=00, PCWrite=1.
    - IRWrite and PCWrite are asserted only in the cycle mem_ready=1 (or always when MEM_HANDSHAKE=0).
    - Exit to DECODE on that cycle.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtrl=00 (branch target precompute). Next state by opcode:
    - 000000 -> RTYPE_EX
    - 100011 or 101011 -> MEMADR
    - 000100 -> BEQ
    - 001000 -> ADDI_EX
    - 001010 -> SLTI_EX
    - 000010 -> JUMP
    - else -> ERROR
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtrl=00 -> MEMRD (lw) or MEMWR (sw). The opcode is re-examined here; the IR is stable.
  - MEMRD: MemRead=1, IorD=1; hold until mem_ready -> MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
  - MEMWR: MemWrite=1, IorD=1; hold until mem_ready -> FETCH. MemWrite stays high while holding.
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUCtrl=10 -> ALU_WB.
  - ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUCtrl=01, Branch=1, PCSrc=01 -> FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUCtrl=00 -> IMM_WB.
  - SLTI_EX: same as ADDI_EX but ALUCtrl=11 -> IMM_WB.
  - IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - JUMP: PCWrite=1, PCSrc=10 -> FETCH.
  - ERROR: all enables 0, illegal_op=1; remains until rst.
- Latency with MEM_HANDSHAKE=0, in cycles from FETCH entry to next FETCH entry:
  - lw 5
  - sw 4
  - R-type, addi, slti 4
  - beq 3
  - j 3
- Each mem_ready=0 cycle in a memory state adds exactly one cycle.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR. mem_ready=1 together with rst: reset wins.
- opcode is ignored in every state except DECODE and MEMADR.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J)
  - ALUCtrl constants (ALUCTRL_ADD/SUB/RTYPE/SLT)
  - ALUSrcB and PCSrc select constants
- No sub-module needed: one file with a next-state block and an output-decode block.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEMWR -> next cycle state=FETCH, MemWrite=0, ALUCtrl=00, illegal_op=0.
- lw with MEM_HANDSHAKE=1, opcode=100011, mem_ready low 2 cycles in MEMRD -> sequence FETCH,DECODE,MEMADR,MEMRD×3,MEMWB; RegWrite=1 and MemtoReg=1 only in MEMWB.
- R-type opcode=000000 -> ALUCtrl=10 in RTYPE_EX; RegWrite=1 and RegDst=1 in ALU_WB; back in FETCH after 4 cycles.
- beq opcode=000100 -> BEQ state shows ALUCtrl=01, Branch=1, PCSrc=01; slti opcode=001010 -> ALUCtrl=11 in SLTI_EX.
- j opcode=000010 -> PCWrite=1, PCSrc=10 for exactly one cycle, then FETCH.
- Illegal opcode 111111 -> ERROR, illegal_op=1 held for 20 cycles with all enables 0 despite opcode changes; cleared only by rst.
